board_scanner: RTL and testbench
================================

Name: board_scanner

Overview:
- Upstream sequencer for the tile renderer. It walks the 16x16 game-board storage (256 tiles, 8-bit address, upper nibble row, lower nibble column) once per start request.
- For each tile it reads the 8-bit tile byte. Empty tiles (0x00) are skipped.
- For each non-empty tile it presents the address and byte to the renderer and holds them until the renderer reports done. A timeout guard stops a stalled renderer from hanging the scan.
- It signals frame completion to the top-level game controller.

Parameters:
- RD_LAT, 1, storage read latency in cycles from ram_addr to valid ram_data (1..3).
- DRAW_TIMEOUT, 300, maximum cycles spent in DRAW per tile before forced advance. It must exceed 256, the wall draw length.
- TO_W, 9, width of the draw-cycle counter; must satisfy 2^TO_W > DRAW_TIMEOUT.

Ports:
- clock  in  1  system clock (50 MHz).
- resetn  in  1  reset; synchronous and active-low.
- start  in  1  request one full-board scan; sampled only in IDLE.
- ram_addr  out  8  storage read address.
- ram_data  in  8  tile byte (bit7 wall, bit6 tank1, bit5 tank2, bit4 projectile, bits3:0 direction/misc).
- tile_address  out  8  latched address presented to renderer.
- tile_position  out  8  latched tile byte presented to renderer.
- draw_go  out  1  high for the whole time renderer output is wanted for the current tile.
- draw_done  in  1  renderer done level.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  single-cycle pulse when scan completes.
- tiles_drawn  out  9  count of non-empty tiles completed by draw_done in the current/last scan.
- timeouts  out  8  count of forced advances in the current/last scan; saturates at 255.

Behaviour:
- Reset (resetn low at a clock edge):
  - state returns to IDLE.
  - All outputs return to 0: ram_addr, tile_address, tile_position, draw_go, busy, frame_done, tiles_drawn, timeouts.
  - Internal counters return to 0.
  - Reset mid-scan aborts immediately; no frame_done is produced.
- States: IDLE, FETCH, EVAL, DRAW, NEXT, FINISH.
- IDLE:
  - busy=0.
  - On start=1: ram_addr<=0, tiles_drawn<=0, timeouts<=0, go to FETCH.
  - start in any other state is ignored.
- FETCH:
  - Holds ram_addr for RD_LAT cycles using a wait counter, then goes to EVAL.
- EVAL (1 cycle), samples ram_data:
  - 0x00: go to NEXT; draw_go stays 0.
  - Otherwise: tile_address<=ram_addr, tile_position<=ram_data, clear the draw counter and seen_low flag, go to DRAW.
- DRAW:
  - draw_go=1; the draw counter increments each cycle.
  - seen_low is set on any cycle with draw_done=0. This rejects a stale done left over from the previous tile.
  - Completion: draw_done=1 while seen_low=1. Then tiles_drawn+1 and go to NEXT.
  - Timeout: draw counter reaches DRAW_TIMEOUT-1 without completion. Then timeouts+1 (saturating) and go to NEXT; tiles_drawn is not incremented.
  - If completion and timeout occur in the same cycle, completion wins.
- NEXT (1 cycle):
  - draw_go=0.
  - If ram_addr==255, go to FINISH.
  - Otherwise ram_addr<=ram_addr+1 and go to FETCH.
  - ram_addr never wraps within a scan.
- FINISH (1 cycle):
  - frame_done=1, then go to IDLE.
  - tile_address, tile_position, tiles_drawn and timeouts hold their values until the next start or reset.
- Cycle counts:
  - Empty tile: RD_LAT+2 cycles (FETCH, EVAL, NEXT).
  - Drawn tile: RD_LAT+2+D cycles, where D is the number of DRAW cycles.
  - Example: empty board, RD_LAT=1, start sampled at cycle 0. frame_done is high at cycle 769, busy is 0 from cycle 770.
- Outputs are registered with no combinational path from inputs to outputs, except busy and draw_go, which are decoded from the state register.

Test Plan:
- All-zero RAM, RD_LAT=1, start pulse: 256 addresses are read in order 0..255; draw_go is never high; frame_done pulses once at cycle 769; tiles_drawn=0, timeouts=0.
- RAM has 0x40 at address 0x35 only; renderer model holds done low for 10 cycles, then high:
  - tile_address=0x35 and tile_position=0x40 for the whole draw_go window.
  - draw_go is high for 11 cycles.
  - tiles_drawn=1 at frame_done.
- Stale done: draw_done held high when DRAW is entered, goes low for 1 cycle at DRAW+3, then high. The tile completes at DRAW+4, not at DRAW+0.
- Renderer never asserts done; walls at 0x00 and 0xFF:
  - Each tile leaves DRAW after exactly 300 cycles.
  - timeouts=2, tiles_drawn=0; the scan still reaches frame_done.
- start asserted repeatedly during a scan has no effect. resetn low at address 0x80 mid-DRAW: the next cycle is IDLE with all outputs 0 and no frame_done. A new start then rescans from address 0.
- RD_LAT=3 with RAM model latency 3, pattern 0x80 at even addresses: tile_position matches RAM at every draw, with no off-by-one address/data pairing; tiles_drawn=128.

Source files
------------

// File: rtl/board_scanner.sv
// board_scanner: walks the 16x16 game board once per start request and hands
// every non-empty tile to the tile renderer, one tile at a time. A draw
// timeout keeps a stalled renderer from hanging the scan. The block raises a
// one-cycle frame_done pulse when the scan completes, and keeps per-scan
// counts of completed draws and forced advances.
module board_scanner #(
  parameter int RD_LAT       = 1,    // storage read latency, 1..3
  parameter int DRAW_TIMEOUT = 300,  // max DRAW cycles per tile (> 256)
  parameter int TO_W         = 9     // draw counter width, 2^TO_W > DRAW_TIMEOUT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  output logic [7:0] ram_addr,
  input  logic [7:0] ram_data,
  output logic [7:0] tile_address,
  output logic [7:0] tile_position,
  output logic       draw_go,
  input  logic       draw_done,
  output logic       busy,
  output logic       frame_done,
  output logic [8:0] tiles_drawn,
  output logic [7:0] timeouts
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EVAL,
    S_DRAW,
    S_NEXT,
    S_FINISH
  } state_t;

  localparam int WAIT_W = 2;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);
  localparam logic [TO_W-1:0]   DRAW_LAST = TO_W'(DRAW_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TO_W-1:0]   draw_cnt;
  logic              seen_low;

  // Decoded conditions shared by the FSM and the datapath.
  logic fetch_done, tile_empty, draw_complete, draw_expired, last_addr;

  assign fetch_done    = (wait_cnt == WAIT_LAST);
  assign tile_empty    = (ram_data == 8'h00);
  // A done level only counts once it has been seen low during this tile, so a
  // done left high from the previous tile cannot finish the new one early.
  assign draw_complete = draw_done && seen_low;
  assign draw_expired  = (draw_cnt == DRAW_LAST);
  assign last_addr     = (ram_addr == 8'hFF);

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  if (fetch_done) state_nxt = S_EVAL;
      S_EVAL:   state_nxt = tile_empty ? S_NEXT : S_DRAW;
      S_DRAW:   if (draw_complete || draw_expired) state_nxt = S_NEXT;
      S_NEXT:   state_nxt = last_addr ? S_FINISH : S_FETCH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded straight from the state register.
  always_comb begin
    busy    = (state != S_IDLE);
    draw_go = (state == S_DRAW);
  end

  // Read address: cleared on start, stepped in NEXT, never wraps in a scan.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ram_addr <= 8'h00;
    end else if (state == S_IDLE && start) begin
      ram_addr <= 8'h00;
    end else if (state == S_NEXT && !last_addr) begin
      ram_addr <= ram_addr + 8'h01;
    end
  end

  // Read-latency wait counter: counts FETCH cycles, idles at zero elsewhere.
  always_ff @(posedge clock) begin
    if (!resetn)               wait_cnt <= '0;
    else if (state == S_FETCH) wait_cnt <= fetch_done ? '0 : wait_cnt + 1'b1;
    else                       wait_cnt <= '0;
  end

  // Draw cycle counter and stale-done filter, armed in EVAL.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      draw_cnt <= '0;
      seen_low <= 1'b0;
    end else if (state == S_EVAL) begin
      draw_cnt <= '0;
      seen_low <= 1'b0;
    end else if (state == S_DRAW) begin
      draw_cnt <= draw_cnt + 1'b1;
      if (!draw_done) seen_low <= 1'b1;
    end
  end

  // Tile latch: captured in EVAL for non-empty tiles, held through the draw
  // and after the scan until overwritten by a later tile or reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      tile_address  <= 8'h00;
      tile_position <= 8'h00;
    end else if (state == S_EVAL && !tile_empty) begin
      tile_address  <= ram_addr;
      tile_position <= ram_data;
    end
  end

  // Per-scan statistics; completion takes priority over a same-cycle timeout.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      tiles_drawn <= 9'd0;
      timeouts    <= 8'd0;
    end else if (state == S_IDLE && start) begin
      tiles_drawn <= 9'd0;
      timeouts    <= 8'd0;
    end else if (state == S_DRAW) begin
      if (draw_complete)
        tiles_drawn <= tiles_drawn + 9'd1;
      else if (draw_expired && timeouts != 8'hFF)
        timeouts <= timeouts + 8'd1;
    end
  end

  // Frame completion pulse, registered so it is high exactly in FINISH.
  always_ff @(posedge clock) begin
    if (!resetn) frame_done <= 1'b0;
    else         frame_done <= (state == S_NEXT) && last_addr;
  end

endmodule

// File: tb/tb_board_scanner.sv
// tb_board_scanner: drives board scans on two scanner instances (read latency
// 1 and 3) with a board RAM model and a scripted renderer, and checks every
// cycle of each scan against a timeline predicted from the tile contents and
// the renderer's done level.
module tb_board_scanner;

  localparam int DT = 300;

  logic       clock = 1'b0;
  logic       resetn;
  logic       draw_done;
  logic       start_s [2];
  logic [7:0] ram_addr_s [2];
  logic [7:0] ram_data_s [2];
  logic [7:0] tile_address_s [2];
  logic [7:0] tile_position_s [2];
  logic       draw_go_s [2];
  logic       busy_s [2];
  logic       frame_done_s [2];
  logic [8:0] tiles_drawn_s [2];
  logic [7:0] timeouts_s [2];

  always #5 clock = ~clock;

  board_scanner #(.RD_LAT(1), .DRAW_TIMEOUT(DT), .TO_W(9)) dut1 (
    .clock(clock), .resetn(resetn), .start(start_s[0]),
    .ram_addr(ram_addr_s[0]), .ram_data(ram_data_s[0]),
    .tile_address(tile_address_s[0]), .tile_position(tile_position_s[0]),
    .draw_go(draw_go_s[0]), .draw_done(draw_done), .busy(busy_s[0]),
    .frame_done(frame_done_s[0]), .tiles_drawn(tiles_drawn_s[0]),
    .timeouts(timeouts_s[0]));

  board_scanner #(.RD_LAT(3), .DRAW_TIMEOUT(DT), .TO_W(9)) dut3 (
    .clock(clock), .resetn(resetn), .start(start_s[1]),
    .ram_addr(ram_addr_s[1]), .ram_data(ram_data_s[1]),
    .tile_address(tile_address_s[1]), .tile_position(tile_position_s[1]),
    .draw_go(draw_go_s[1]), .draw_done(draw_done), .busy(busy_s[1]),
    .frame_done(frame_done_s[1]), .tiles_drawn(tiles_drawn_s[1]),
    .timeouts(timeouts_s[1]));

  // Board storage with per-instance read latency.
  logic [7:0] mem [256];
  logic [7:0] p1, p2;
  always @(posedge clock) ram_data_s[0] <= mem[ram_addr_s[0]];
  always @(posedge clock) begin
    p1 <= mem[ram_addr_s[1]];
    p2 <= p1;
    ram_data_s[1] <= p2;
  end

  // Renderer: 0 fixed delay, 1 random delay, 2 never done, 3 stale done.
  int   sel = 0;
  int   mode = 0;
  int   fixed_delay = 10;
  int   delay_n = 0;
  int   rk = 0;
  logic go_prev = 1'b0;
  always @(posedge clock) begin
    logic g;
    #1;
    g = draw_go_s[sel];
    if (g) begin
      if (!go_prev) begin
        rk = 0;
        if (mode == 1)
          delay_n = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 12));
        else
          delay_n = fixed_delay;
      end else rk++;
    end
    case (mode)
      0, 1:    draw_done = g && (rk >= delay_n);
      2:       draw_done = 1'b0;
      default: draw_done = g ? (rk != 3) : 1'b1;
    endcase
    go_prev = g;
  end

  // Scoreboard and expected state.
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int noise = 0;
  int fd_cycle = 0;
  int draw_lens [$];
  int exp_drawn [2];
  int exp_to [2];
  int last_ta [2];
  int last_tp [2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle(input int s, input int busy_e, input int go_e,
                             input int addr_e, input int fd_e);
    chk("busy", int'(busy_s[s]), busy_e);
    chk("draw_go", int'(draw_go_s[s]), go_e);
    chk("ram_addr", int'(ram_addr_s[s]), addr_e);
    chk("frame_done", int'(frame_done_s[s]), fd_e);
    chk("tiles_drawn", int'(tiles_drawn_s[s]), exp_drawn[s]);
    chk("timeouts", int'(timeouts_s[s]), exp_to[s]);
  endtask

  task automatic check_zero(input int s);
    check_cycle(s, 0, 0, 0, 0);
    chk("rst_tile_address", int'(tile_address_s[s]), 0);
    chk("rst_tile_position", int'(tile_position_s[s]), 0);
  endtask

  task automatic step(input int s);
    @(negedge clock);
    cyc++;
    start_s[s] = (noise != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_drawn[i] = 0; exp_to[i] = 0; last_ta[i] = 0; last_tp[i] = 0;
    end
  endtask

  // One full scan on instance s; abort_addr >= 0 pulls reset in that tile's
  // fifth DRAW cycle and checks the aborted state instead of finishing.
  task automatic run_scan(input int s, input int abort_addr);
    int lat;
    lat = (s == 0) ? 1 : 3;
    draw_lens.delete();
    @(negedge clock);
    start_s[s] = 1'b1;
    cyc = 0;
    exp_drawn[s] = 0;
    exp_to[s] = 0;
    for (int a = 0; a < 256; a++) begin
      for (int w = 0; w < lat; w++) begin
        step(s);
        check_cycle(s, 1, 0, a, 0);
      end
      step(s);
      check_cycle(s, 1, 0, a, 0);
      if (mem[a] != 8'h00) begin
        int  d;
        bit  seen, fin;
        logic dd;
        d = 0; seen = 0; fin = 0;
        while (!fin) begin
          step(s);
          check_cycle(s, 1, 1, a, 0);
          chk("tile_address", int'(tile_address_s[s]), a);
          chk("tile_position", int'(tile_position_s[s]), int'(mem[a]));
          if (a == abort_addr && d == 4) begin
            resetn = 1'b0;
            step(s);
            start_s[s] = 1'b0;
            resetn = 1'b1;
            model_reset();
            for (int r = 0; r < 4; r++) begin
              check_zero(s);
              step(s);
              start_s[s] = 1'b0;
            end
            return;
          end
          dd = draw_done;
          if (dd && seen) begin
            exp_drawn[s]++;
            fin = 1;
          end else if (d == DT - 1) begin
            exp_to[s] = (exp_to[s] == 255) ? 255 : exp_to[s] + 1;
            fin = 1;
          end
          if (!dd) seen = 1;
          d++;
        end
        last_ta[s] = a;
        last_tp[s] = int'(mem[a]);
        draw_lens.push_back(d);
      end
      step(s);
      check_cycle(s, 1, 0, a, 0);
    end
    step(s);
    check_cycle(s, 1, 0, 255, 1);
    fd_cycle = cyc;
    step(s);
    start_s[s] = 1'b0;
    check_cycle(s, 0, 0, 255, 0);
    chk("hold_tile_address", int'(tile_address_s[s]), last_ta[s]);
    chk("hold_tile_position", int'(tile_position_s[s]), last_tp[s]);
  endtask

  initial begin
    resetn = 1'b0;
    start_s[0] = 1'b0;
    start_s[1] = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    model_reset();
    repeat (3) @(negedge clock);
    check_zero(0);
    check_zero(1);
    resetn = 1'b1;

    // Empty board: pure walk, frame_done at cycle 769.
    sel = 0; mode = 0;
    run_scan(0, -1);
    chk("empty_fd_cycle", fd_cycle, 769);
    chk("empty_draws", draw_lens.size(), 0);
    chk("empty_tiles_drawn", int'(tiles_drawn_s[0]), 0);

    // Single tank tile, renderer done after 10 low cycles.
    mem[8'h35] = 8'h40; fixed_delay = 10;
    run_scan(0, -1);
    chk("one_tile_draws", draw_lens.size(), 1);
    if (draw_lens.size() > 0) chk("one_tile_len", draw_lens[0], 11);
    chk("one_tile_tiles_drawn", int'(tiles_drawn_s[0]), 1);
    chk("one_tile_address", int'(tile_address_s[0]), 8'h35);

    // Stale done: must complete at DRAW+4.
    mode = 3;
    run_scan(0, -1);
    if (draw_lens.size() > 0) chk("stale_len", draw_lens[0], 5);
    chk("stale_tiles_drawn", int'(tiles_drawn_s[0]), 1);

    // Dead renderer, walls at both corners.
    mem[8'h35] = 8'h00; mem[8'h00] = 8'h80; mem[8'hFF] = 8'h80; mode = 2;
    run_scan(0, -1);
    chk("dead_draws", draw_lens.size(), 2);
    if (draw_lens.size() == 2) begin
      chk("dead_len0", draw_lens[0], 300);
      chk("dead_len1", draw_lens[1], 300);
    end
    chk("dead_timeouts", int'(timeouts_s[0]), 2);
    chk("dead_tiles_drawn", int'(tiles_drawn_s[0]), 0);

    // Random board, noisy start, reset in the middle of drawing 0x80.
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    mem[8'h80] = 8'h90;
    mode = 0; fixed_delay = 10; noise = 1;
    run_scan(0, 8'h80);
    // Rescan from address 0 with random renderer delays.
    mode = 1;
    run_scan(0, -1);
    noise = 0;

    // Latency-3 instance, walls on even addresses.
    for (int i = 0; i < 256; i++) mem[i] = (i % 2 == 0) ? 8'h80 : 8'h00;
    sel = 1; mode = 0; fixed_delay = 3;
    run_scan(1, -1);
    chk("lat3_tiles_drawn", int'(tiles_drawn_s[1]), 128);
    chk("lat3_draws", draw_lens.size(), 128);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
